// File: rtl/axi_id_remap_pkg.sv
// Shared types and helpers for the AXI ID remapper.
// The optional stats outputs are enabled by defining ID_REMAP_STATS_EN.
package axi_id_remap_pkg;

    localparam int DEF_WIDE_ID_W = 16;
    localparam int DEF_CNT_W     = 4;
    localparam int MAX_SLOTS     = 64;
    localparam int UNMAPPED_ID   = 0;

    typedef struct packed {
        logic                     valid;
        logic [DEF_WIDE_ID_W-1:0] wide_id;
        logic [DEF_CNT_W-1:0]     cnt;
    } slot_t;

    // Returns the lowest set index of free, or -1 when none is set.
    function automatic int lowest_free(input logic [MAX_SLOTS-1:0] free);
        int idx;
        idx = -1;
        for (int i = MAX_SLOTS - 1; i >= 0; i--) begin
            if (free[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/axi_id_remap_table.sv
// Remap table: slot state, wide-ID CAM lookup, free-slot allocation
// and outstanding-count bookkeeping.
module axi_id_remap_table
    import axi_id_remap_pkg::*;
#(
    parameter int WIDE_ID_W   = 16,
    parameter int NARROW_ID_W = 6,
    parameter int N_SLOTS     = 8,
    parameter int CNT_W       = 4,
    parameter int ACT_W       = $clog2(N_SLOTS + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDE_ID_W-1:0]   req_id,
    input  logic                   req_fire,
    output logic                   can_map,
    output logic [NARROW_ID_W-1:0] req_slot,
    input  logic [NARROW_ID_W-1:0] rsp_id,
    input  logic                   rsp_done,
    output logic                   rsp_mapped,
    output logic [WIDE_ID_W-1:0]   rsp_wide_id,
    output logic [ACT_W-1:0]       active_slots
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic                 valid;
        logic [WIDE_ID_W-1:0] wide_id;
        logic [CNT_W-1:0]     cnt;
    } entry_t;

    entry_t tbl_q [N_SLOTS];

    logic                   hit;
    logic                   hit_full;
    logic                   free_any;
    logic [NARROW_ID_W-1:0] hit_idx;
    logic [NARROW_ID_W-1:0] free_idx;
    logic [MAX_SLOTS-1:0]   free_mask;
    int                     free_pos;
    logic [N_SLOTS-1:0]     inc;
    logic [N_SLOTS-1:0]     dec;

    // A full hit must stall: using another slot would break same-ID order.
    always_comb begin
        hit       = 1'b0;
        hit_full  = 1'b0;
        hit_idx   = '0;
        free_mask = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            free_mask[i] = !tbl_q[i].valid;
            if (tbl_q[i].valid && tbl_q[i].wide_id == req_id) begin
                hit      = 1'b1;
                hit_full = tbl_q[i].cnt == CNT_MAX;
                hit_idx  = NARROW_ID_W'(i);
            end
        end
        free_pos = lowest_free(free_mask);
        free_any = free_pos >= 0;
        free_idx = NARROW_ID_W'(free_pos);
        unique case (1'b1)
            hit: begin
                can_map  = !hit_full;
                req_slot = hit_idx;
            end
            default: begin
                can_map  = free_any;
                req_slot = free_idx;
            end
        endcase
    end

    always_comb begin
        rsp_mapped  = 1'b0;
        rsp_wide_id = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (rsp_id == NARROW_ID_W'(i) && tbl_q[i].valid) begin
                rsp_mapped  = 1'b1;
                rsp_wide_id = tbl_q[i].wide_id;
            end
        end
    end

    always_comb begin
        active_slots = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            active_slots += ACT_W'(tbl_q[i].valid);
        end
    end

    always_comb begin
        for (int i = 0; i < N_SLOTS; i++) begin
            inc[i] = req_fire && req_slot == NARROW_ID_W'(i);
            dec[i] = rsp_done && rsp_id == NARROW_ID_W'(i);
        end
    end

    // inc and dec together leave the slot untouched (cnt - 1 + 1).
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_SLOTS; i++) tbl_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_SLOTS; i++) begin
                unique case ({inc[i], dec[i]})
                    2'b10: begin
                        if (tbl_q[i].valid) begin
                            tbl_q[i].cnt <= tbl_q[i].cnt + 1'b1;
                        end else begin
                            tbl_q[i].valid   <= 1'b1;
                            tbl_q[i].wide_id <= req_id;
                            tbl_q[i].cnt     <= CNT_W'(1);
                        end
                    end
                    2'b01: begin
                        tbl_q[i].cnt <= tbl_q[i].cnt - 1'b1;
                        if (tbl_q[i].cnt == CNT_W'(1)) tbl_q[i].valid <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/axi_id_remap_chan.sv
// Lossless AXI4 ID narrowing for one request/response channel pair.
// Define ID_REMAP_STATS_EN to add the stall_cycles/peak_active outputs.
module axi_id_remap_chan
    import axi_id_remap_pkg::*;
#(
    parameter int WIDE_ID_W   = 16,
    parameter int NARROW_ID_W = 6,
    parameter int N_SLOTS     = 8,
    parameter int CNT_W       = 4,
    parameter int REQ_W       = 64,
    parameter int RSP_W       = 514
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_req_valid,
    output logic                   s_req_ready,
    input  logic [WIDE_ID_W-1:0]   s_req_id,
    input  logic [REQ_W-1:0]       s_req_payload,
    output logic                   m_req_valid,
    input  logic                   m_req_ready,
    output logic [NARROW_ID_W-1:0] m_req_id,
    output logic [REQ_W-1:0]       m_req_payload,
    input  logic                   m_rsp_valid,
    output logic                   m_rsp_ready,
    input  logic [NARROW_ID_W-1:0] m_rsp_id,
    input  logic                   m_rsp_last,
    input  logic [RSP_W-1:0]       m_rsp_payload,
    output logic                   s_rsp_valid,
    input  logic                   s_rsp_ready,
    output logic [WIDE_ID_W-1:0]   s_rsp_id,
    output logic                   s_rsp_last,
    output logic [RSP_W-1:0]       s_rsp_payload,
    output logic [$clog2(N_SLOTS+1)-1:0] active_slots,
`ifdef ID_REMAP_STATS_EN
    output logic [31:0]            stall_cycles,
    output logic [$clog2(N_SLOTS+1)-1:0] peak_active,
`endif
    output logic                   err_unmapped
);

    logic                   can_map;
    logic                   out_free;
    logic                   req_fire;
    logic                   rsp_fire;
    logic                   rsp_mapped;
    logic [NARROW_ID_W-1:0] req_slot;
    logic [WIDE_ID_W-1:0]   rsp_wide_id;

    assign out_free    = !m_req_valid || m_req_ready;
    assign s_req_ready = out_free && can_map;
    assign req_fire    = s_req_valid && s_req_ready;

    assign s_rsp_valid   = m_rsp_valid;
    assign m_rsp_ready   = s_rsp_ready;
    assign s_rsp_last    = m_rsp_last;
    assign s_rsp_payload = m_rsp_payload;
    assign rsp_fire      = m_rsp_valid && s_rsp_ready;
    assign s_rsp_id      = rsp_mapped ? rsp_wide_id
                                      : WIDE_ID_W'(UNMAPPED_ID);

    axi_id_remap_table #(
        .WIDE_ID_W  (WIDE_ID_W),
        .NARROW_ID_W(NARROW_ID_W),
        .N_SLOTS    (N_SLOTS),
        .CNT_W      (CNT_W)
    ) u_table (
        .clk         (clk),
        .reset       (reset),
        .req_id      (s_req_id),
        .req_fire    (req_fire),
        .can_map     (can_map),
        .req_slot    (req_slot),
        .rsp_id      (m_rsp_id),
        .rsp_done    (rsp_fire && m_rsp_last && rsp_mapped),
        .rsp_mapped  (rsp_mapped),
        .rsp_wide_id (rsp_wide_id),
        .active_slots(active_slots)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            m_req_valid   <= 1'b0;
            m_req_id      <= '0;
            m_req_payload <= '0;
        end else if (req_fire) begin
            m_req_valid   <= 1'b1;
            m_req_id      <= req_slot;
            m_req_payload <= s_req_payload;
        end else if (m_req_ready) begin
            m_req_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_unmapped <= 1'b0;
        end else if (rsp_fire && !rsp_mapped) begin
            err_unmapped <= 1'b1;
        end
    end

`ifdef ID_REMAP_STATS_EN
    // Only mapping stalls count; plain downstream backpressure does not.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            peak_active  <= '0;
        end else begin
            if (s_req_valid && !s_req_ready && out_free
                && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (active_slots > peak_active) peak_active <= active_slots;
        end
    end
`endif

endmodule

// File: tb/tb_axi_id_remap_chan.sv
// Self-checking bench for axi_id_remap_chan: vector tables, a request
// scoreboard and hand-written sequences for the multi-cycle corners.
module tb_axi_id_remap_chan;

    localparam int WIDE_ID_W   = 16;
    localparam int NARROW_ID_W = 6;
    localparam int N_SLOTS     = 8;
    localparam int CNT_W       = 4;
    localparam int REQ_W       = 64;
    localparam int RSP_W       = 514;
    localparam int ACT_W       = $clog2(N_SLOTS + 1);
    localparam int CMP_W       = 520;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   s_req_valid;
    logic                   s_req_ready;
    logic [WIDE_ID_W-1:0]   s_req_id;
    logic [REQ_W-1:0]       s_req_payload;
    logic                   m_req_valid;
    logic                   m_req_ready;
    logic [NARROW_ID_W-1:0] m_req_id;
    logic [REQ_W-1:0]       m_req_payload;
    logic                   m_rsp_valid;
    logic                   m_rsp_ready;
    logic [NARROW_ID_W-1:0] m_rsp_id;
    logic                   m_rsp_last;
    logic [RSP_W-1:0]       m_rsp_payload;
    logic                   s_rsp_valid;
    logic                   s_rsp_ready;
    logic [WIDE_ID_W-1:0]   s_rsp_id;
    logic                   s_rsp_last;
    logic [RSP_W-1:0]       s_rsp_payload;
    logic [ACT_W-1:0]       active_slots;
    logic                   err_unmapped;
`ifdef ID_REMAP_STATS_EN
    logic [31:0]            stall_cycles;
    logic [ACT_W-1:0]       peak_active;
`endif

    always #5 clk = ~clk;

    axi_id_remap_chan #(
        .WIDE_ID_W(WIDE_ID_W), .NARROW_ID_W(NARROW_ID_W),
        .N_SLOTS(N_SLOTS), .CNT_W(CNT_W), .REQ_W(REQ_W), .RSP_W(RSP_W)
    ) dut (
        .clk(clk), .reset(reset),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
        .s_req_id(s_req_id), .s_req_payload(s_req_payload),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
        .m_req_id(m_req_id), .m_req_payload(m_req_payload),
        .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready),
        .m_rsp_id(m_rsp_id), .m_rsp_last(m_rsp_last),
        .m_rsp_payload(m_rsp_payload),
        .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready),
        .s_rsp_id(s_rsp_id), .s_rsp_last(s_rsp_last),
        .s_rsp_payload(s_rsp_payload),
        .active_slots(active_slots),
`ifdef ID_REMAP_STATS_EN
        .stall_cycles(stall_cycles), .peak_active(peak_active),
`endif
        .err_unmapped(err_unmapped)
    );

    typedef struct {
        logic [NARROW_ID_W-1:0] slot;
        logic [REQ_W-1:0]       payload;
    } exp_req_t;

    typedef struct {
        logic [WIDE_ID_W-1:0]   id;
        logic [NARROW_ID_W-1:0] slot;
        logic [ACT_W-1:0]       act;
    } vec_t;

    exp_req_t req_q[$];
    exp_req_t mon_e;
    vec_t     v2 [3];
    int       errors = 0;
    int       checks = 0;

    task automatic chk(input string name,
                       input logic [CMP_W-1:0] act,
                       input logic [CMP_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [RSP_W-1:0] rand_rsp();
        logic [RSP_W-1:0] r;
        r = '0;
        for (int k = 0; k < 17; k++) r = (r << 32) | RSP_W'($urandom);
        return r;
    endfunction

    // Scoreboard: every accepted downstream request must match in order.
    always @(negedge clk) begin
        if (!reset && m_req_valid && m_req_ready) begin
            if (req_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL m_req_extra: got id %0h want none", m_req_id);
            end else begin
                mon_e = req_q.pop_front();
                chk("m_req_id", CMP_W'(m_req_id), CMP_W'(mon_e.slot));
                chk("m_req_payload", CMP_W'(m_req_payload),
                    CMP_W'(mon_e.payload));
            end
        end
    end

    task automatic send_req(input logic [WIDE_ID_W-1:0] id,
                            input logic [NARROW_ID_W-1:0] slot);
        exp_req_t e;
        int n;
        s_req_valid   = 1'b1;
        s_req_id      = id;
        s_req_payload = {$urandom, $urandom};
        n = 0;
        @(negedge clk);
        while (!s_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (s_req_ready) begin
            e.slot    = slot;
            e.payload = s_req_payload;
            req_q.push_back(e);
        end else begin
            checks++;
            errors++;
            $display("FAIL req_timeout: id %0h ready 0 want 1", id);
        end
        @(posedge clk);
        #1;
        s_req_valid = 1'b0;
        chk("m_req_valid_lat", CMP_W'(m_req_valid), CMP_W'(1));
    endtask

    task automatic send_rsp(input logic [NARROW_ID_W-1:0] id,
                            input logic last,
                            input logic [WIDE_ID_W-1:0] exp_id);
        m_rsp_valid   = 1'b1;
        m_rsp_id      = id;
        m_rsp_last    = last;
        m_rsp_payload = rand_rsp();
        @(negedge clk);
        chk("s_rsp_valid", CMP_W'(s_rsp_valid), CMP_W'(1));
        chk("s_rsp_id", CMP_W'(s_rsp_id), CMP_W'(exp_id));
        chk("s_rsp_last", CMP_W'(s_rsp_last), CMP_W'(last));
        chk("s_rsp_payload", CMP_W'(s_rsp_payload), CMP_W'(m_rsp_payload));
        chk("m_rsp_ready", CMP_W'(m_rsp_ready), CMP_W'(s_rsp_ready));
        @(posedge clk);
        #1;
        m_rsp_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [NARROW_ID_W-1:0] slot);
        exp_req_t e;
        e.slot    = slot;
        e.payload = s_req_payload;
        req_q.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        s_req_valid = 1'b0; s_req_id = '0; s_req_payload = '0;
        m_req_ready = 1'b1;
        m_rsp_valid = 1'b0; m_rsp_id = '0; m_rsp_last = 1'b0;
        m_rsp_payload = '0; s_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_m_req_valid", CMP_W'(m_req_valid), CMP_W'(0));
        chk("rst_err", CMP_W'(err_unmapped), CMP_W'(0));
        chk("rst_active", CMP_W'(active_slots), CMP_W'(0));
        chk("rst_s_rsp_valid", CMP_W'(s_rsp_valid), CMP_W'(0));

        // Single read burst on one wide ID.
        send_req(16'h1234, 6'd0);
        chk("t1_active1", CMP_W'(active_slots), CMP_W'(1));
        send_rsp(6'd0, 1'b0, 16'h1234);
        send_rsp(6'd0, 1'b0, 16'h1234);
        chk("t1_active_mid", CMP_W'(active_slots), CMP_W'(1));
        send_rsp(6'd0, 1'b1, 16'h1234);
        chk("t1_active0", CMP_W'(active_slots), CMP_W'(0));

        // Same-ID reuse and a second ID.
        v2[0] = '{id: 16'h0007, slot: 6'd0, act: 4'd1};
        v2[1] = '{id: 16'h0009, slot: 6'd1, act: 4'd2};
        v2[2] = '{id: 16'h0007, slot: 6'd0, act: 4'd2};
        for (int i = 0; i < 3; i++) begin
            send_req(v2[i].id, v2[i].slot);
            chk("t2_active", CMP_W'(active_slots), CMP_W'(v2[i].act));
        end
        send_rsp(6'd0, 1'b1, 16'h0007);
        chk("t2_slot0_kept", CMP_W'(active_slots), CMP_W'(2));
        send_rsp(6'd0, 1'b1, 16'h0007);
        chk("t2_slot0_freed", CMP_W'(active_slots), CMP_W'(1));
        send_rsp(6'd1, 1'b1, 16'h0009);
        chk("t2_all_free", CMP_W'(active_slots), CMP_W'(0));

        // Fill every slot, then a ninth ID must wait for a free slot.
        for (int i = 0; i < N_SLOTS; i++) begin
            send_req(16'h0100 + 16'(i), NARROW_ID_W'(i));
        end
        chk("t3_full", CMP_W'(active_slots), CMP_W'(N_SLOTS));
        s_req_valid = 1'b1;
        s_req_id = 16'h0200;
        s_req_payload = {$urandom, $urandom};
        repeat (3) begin
            @(negedge clk);
            chk("t3_stall", CMP_W'(s_req_ready), CMP_W'(0));
        end
        @(posedge clk);
        #1;
        m_rsp_valid = 1'b1; m_rsp_id = 6'd3; m_rsp_last = 1'b1;
        @(negedge clk);
        chk("t3_free_rsp_id", CMP_W'(s_rsp_id), CMP_W'(16'h0103));
        chk("t3_free_not_visible", CMP_W'(s_req_ready), CMP_W'(0));
        @(posedge clk);
        #1;
        m_rsp_valid = 1'b0;
        @(negedge clk);
        chk("t3_ready_after_free", CMP_W'(s_req_ready), CMP_W'(1));
        push_exp(6'd3);
        @(posedge clk);
        #1;
        s_req_valid = 1'b0;
        for (int i = 0; i < N_SLOTS; i++) begin
            send_rsp(NARROW_ID_W'(i), 1'b1,
                     (i == 3) ? 16'h0200 : 16'h0100 + 16'(i));
        end
        chk("t3_drained", CMP_W'(active_slots), CMP_W'(0));

        // Counter saturation on one ID.
        for (int i = 0; i < 15; i++) send_req(16'h0abc, 6'd0);
        chk("t4_one_slot", CMP_W'(active_slots), CMP_W'(1));
        s_req_valid = 1'b1;
        s_req_id = 16'h0abc;
        s_req_payload = {$urandom, $urandom};
        repeat (2) begin
            @(negedge clk);
            chk("t4_stall", CMP_W'(s_req_ready), CMP_W'(0));
        end
        @(posedge clk);
        #1;
        m_rsp_valid = 1'b1; m_rsp_id = 6'd0; m_rsp_last = 1'b1;
        @(negedge clk);
        chk("t4_rsp_id", CMP_W'(s_rsp_id), CMP_W'(16'h0abc));
        chk("t4_still_full", CMP_W'(s_req_ready), CMP_W'(0));
        @(posedge clk);
        #1;
        m_rsp_valid = 1'b0;
        @(negedge clk);
        chk("t4_accept", CMP_W'(s_req_ready), CMP_W'(1));
        push_exp(6'd0);
        @(posedge clk);
        #1;
        s_req_valid = 1'b0;
        for (int k = 0; k < 15; k++) begin
            send_rsp(6'd0, 1'b1, 16'h0abc);
            if (k == 13) chk("t4_last_left", CMP_W'(active_slots), CMP_W'(1));
        end
        chk("t4_drained", CMP_W'(active_slots), CMP_W'(0));

        // Hit and final response on slot 2 in the same cycle.
        send_req(16'h0011, 6'd0);
        send_req(16'h0022, 6'd1);
        send_req(16'h0033, 6'd2);
        s_req_valid = 1'b1;
        s_req_id = 16'h0033;
        s_req_payload = {$urandom, $urandom};
        m_rsp_valid = 1'b1; m_rsp_id = 6'd2; m_rsp_last = 1'b1;
        @(negedge clk);
        chk("t5_ready", CMP_W'(s_req_ready), CMP_W'(1));
        chk("t5_rsp_id", CMP_W'(s_rsp_id), CMP_W'(16'h0033));
        push_exp(6'd2);
        @(posedge clk);
        #1;
        s_req_valid = 1'b0;
        m_rsp_valid = 1'b0;
        chk("t5_kept", CMP_W'(active_slots), CMP_W'(3));
        send_rsp(6'd2, 1'b1, 16'h0033);
        chk("t5_cnt_one", CMP_W'(active_slots), CMP_W'(2));
        send_rsp(6'd0, 1'b1, 16'h0011);
        send_rsp(6'd1, 1'b1, 16'h0022);
        chk("t5_drained", CMP_W'(active_slots), CMP_W'(0));

        // Downstream backpressure holds the output register.
        m_req_ready = 1'b0;
        send_req(16'h0044, 6'd0);
        s_req_valid = 1'b1;
        s_req_id = 16'h0044;
        s_req_payload = {$urandom, $urandom};
        @(negedge clk);
        chk("t6_bp_stall", CMP_W'(s_req_ready), CMP_W'(0));
        chk("t6_bp_hold", CMP_W'(m_req_valid), CMP_W'(1));
        @(posedge clk);
        #1;
        m_req_ready = 1'b1;
        @(negedge clk);
        chk("t6_bp_release", CMP_W'(s_req_ready), CMP_W'(1));
        push_exp(6'd0);
        @(posedge clk);
        #1;
        s_req_valid = 1'b0;
        send_rsp(6'd0, 1'b1, 16'h0044);
        chk("t6_cnt2", CMP_W'(active_slots), CMP_W'(1));
        send_rsp(6'd0, 1'b1, 16'h0044);
        chk("t6_drained", CMP_W'(active_slots), CMP_W'(0));

        // Unmapped responses, sticky error, reset clears everything.
        send_rsp(6'd5, 1'b1, 16'h0000);
        chk("t7_err_set", CMP_W'(err_unmapped), CMP_W'(1));
        send_rsp(6'd9, 1'b0, 16'h0000);
        chk("t7_err_held", CMP_W'(err_unmapped), CMP_W'(1));
        chk("t7_no_change", CMP_W'(active_slots), CMP_W'(0));
        send_req(16'h0055, 6'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("t7_rst_err", CMP_W'(err_unmapped), CMP_W'(0));
        chk("t7_rst_active", CMP_W'(active_slots), CMP_W'(0));
        chk("t7_rst_m_req", CMP_W'(m_req_valid), CMP_W'(0));
        send_rsp(6'd0, 1'b1, 16'h0000);
        chk("t7_err_after_rst", CMP_W'(err_unmapped), CMP_W'(1));

        chk("req_q_empty", CMP_W'(req_q.size()), CMP_W'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_id_remap_chan.md
Name: axi_id_remap_chan

Overview:
- Lossless AXI4 ID narrowing for one request/response channel pair: AR/R, or AW/B with last tied high.
- Replaces the plain ID truncation between the 16-bit-ID core and the narrow-ID DDR/host ports.
- Maps each active wide ID to a narrow slot index and restores the wide ID on responses.
- Preserves AXI same-ID ordering: all in-flight transactions of one wide ID share one slot.
- Top level instantiates it twice per DDR port (read and write).

Parameters:
- WIDE_ID_W, 16, request-side (upstream) ID width.
- NARROW_ID_W, 6, downstream ID width.
- N_SLOTS, 8, remap table entries; must be <= 2**NARROW_ID_W.
- CNT_W, 4, per-slot outstanding counter width; max outstanding per slot = 2**CNT_W-1.
- REQ_W, 64, opaque request payload width (addr/len/size/burst/... concatenated).
- RSP_W, 514, opaque response payload width (data/resp).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_req_valid/s_req_ready  in/out  1/1  upstream request handshake
- s_req_id  in  WIDE_ID_W  upstream ID
- s_req_payload  in  REQ_W
- m_req_valid/m_req_ready  out/in  1/1  downstream request handshake
- m_req_id  out  NARROW_ID_W  slot index, zero-extended
- m_req_payload  out  REQ_W
- m_rsp_valid/m_rsp_ready  in/out  1/1  downstream response handshake
- m_rsp_id  in  NARROW_ID_W
- m_rsp_last  in  1  last beat; tie 1 for B
- m_rsp_payload  in  RSP_W
- s_rsp_valid/s_rsp_ready  out/in  1/1  upstream response handshake
- s_rsp_id  out  WIDE_ID_W  restored wide ID
- s_rsp_last  out  1
- s_rsp_payload  out  RSP_W
- active_slots  out  $clog2(N_SLOTS+1)  number of valid slots
- err_unmapped  out  1  sticky; response arrived for an invalid slot

Behaviour:
- Slot state: valid bit, wide_id[WIDE_ID_W], cnt[CNT_W]. Reset clears all valid bits and counts.
- Reset values: m_req_valid=0, err_unmapped=0, active_slots=0. Response path is combinational, so s_rsp_valid=0 follows from m_rsp_valid=0.
- Request path: one-stage output register, latency 1 cycle from s_req handshake to m_req_valid.
- s_req_ready = (!m_req_valid || m_req_ready) && can_map.
- can_map evaluation:
  - Hit: a valid slot with wide_id==s_req_id and cnt<max. Use that slot, cnt++.
  - Hit with cnt==max: stall. No allocation in another slot; that would break ordering.
  - Miss: allocate the lowest-index invalid slot, set valid, wide_id=s_req_id, cnt=1.
  - Miss with no free slot: stall.
- Allocation/increment commits on the s_req handshake, before downstream acceptance. This is legal because a response cannot precede its request.
- Response path: 0-cycle pass-through.
  - s_rsp_valid=m_rsp_valid; m_rsp_ready=s_rsp_ready.
  - s_rsp_id=table[m_rsp_id].wide_id; last and payload are unchanged.
- On a response handshake with last=1: cnt--. If cnt reaches 0, clear valid (slot freed).
- Response for an invalid slot, or m_rsp_id>=N_SLOTS:
  - Pass through with s_rsp_id=0.
  - No counter change.
  - Set err_unmapped; it stays set until reset.
- Simultaneous events:
  - Increment and last-decrement on the same slot in one cycle: cnt unchanged, slot stays valid.
  - Slot freed this cycle: not visible to the allocator until the next cycle. The allocator always uses registered state.
  - Request hits a slot whose final response completes in the same cycle: treated as a hit; cnt = cnt - 1 + 1.
- Reset mid-operation discards all mappings. Downstream in-flight responses afterwards flag err_unmapped; this is the system's responsibility.
- With N_SLOTS==1, all IDs serialise through slot 0.

Optional Feature:
- ID_REMAP_STATS_EN defined: adds two outputs.
  - stall_cycles[31:0]: counts cycles with s_req_valid && !s_req_ready && (!m_req_valid || m_req_ready), i.e. mapping stalls only. Saturates at 2**32-1.
  - peak_active: width of active_slots; running maximum of active_slots.
  - Both reset to 0.
- Not defined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package axi_id_remap_pkg:
  - slot entry struct typedef (valid, wide_id, cnt), parameterised by widths via localparam helpers;
  - function for lowest-free-index priority encode;
  - constant for the unmapped-response ID (0).
- Sub-module axi_id_remap_table:
  - holds slot state, CAM lookup, free-slot encoder, inc/dec/free update logic;
  - outputs hit/slot/can_map for the request side and wide_id/valid for the response side.
- The channel wrapper holds the output register, handshakes and the error flag.

Test Plan:
- Single request id=0x1234, then R beats last=0,0,1 on m_rsp_id=0:
  - m_req_id=0 one cycle after the handshake;
  - s_rsp_id=0x1234 on all three beats;
  - slot 0 freed after the last beat; active_slots 1->0.
- Three requests id=0x0007, then 0x0009, then 0x0007:
  - m_req_id sequence 0,1,0;
  - slot0 cnt=2;
  - B on id 0 twice frees slot 0; slot 1 stays valid.
- 8 distinct IDs fill N_SLOTS=8, ninth distinct ID:
  - s_req_ready=0 until one slot frees;
  - the following cycle the request issues with the freed index.
- Same ID issued 15 times (CNT_W=4):
  - 16th request stalls;
  - after one last-response, the 16th is accepted on the next s_req_valid cycle.
- Same-cycle request hit and final response on slot 2 (cnt=1): slot 2 stays valid with cnt=1; m_req_id=2.
- m_rsp_id=5 with slot 5 invalid:
  - s_rsp_id=0, err_unmapped=1 and held;
  - reset then clears err_unmapped and all slots.
